// File: rtl/cache_pkg.sv
// Shared widths, types and address helpers for the cache miss path.
package cache_pkg;

    localparam int unsigned TAG_W  = 36;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned OFF_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BEATS  = 4;
    localparam int unsigned ADDR_W = TAG_W + IDX_W + OFF_W;

    typedef logic [1:0] way_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        COMMIT
    } refill_state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W +: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W-1:0];
    endfunction

endpackage

// File: rtl/victim_select.sv
// Victim way choice: first invalid way wins, otherwise the per-set round-robin pointer.
module victim_select #(
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       vbit,
    input  logic [IDX_W-1:0] idx,
    input  logic             upd,
    input  logic [IDX_W-1:0] upd_idx,
    input  cache_pkg::way_t  upd_way,
    output cache_pkg::way_t  victim,
    output logic             from_ptr
);

    localparam int unsigned NSETS = 2 ** IDX_W;

    logic [1:0] ptr_q [NSETS];
    logic [1:0] ptr_d [NSETS];

    // Invalid-first priority; fall back to the set's pointer only for a full set.
    always_comb begin
        victim   = ptr_q[idx];
        from_ptr = 1'b0;
        if (!vbit[0]) begin
            victim = 2'd0;
        end else if (!vbit[1]) begin
            victim = 2'd1;
        end else if (!vbit[2]) begin
            victim = 2'd2;
        end else if (!vbit[3]) begin
            victim = 2'd3;
        end else begin
            from_ptr = 1'b1;
        end
    end

    // Advance the pointer past the way just replaced; 2-bit add wraps 3 -> 0.
    always_comb begin
        ptr_d = ptr_q;
        if (upd) begin
            ptr_d[upd_idx] = upd_way + 2'd1;
        end
    end

    // Pointer array state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NSETS; i++) begin
                ptr_q[i] <= 2'd0;
            end
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-side refill controller: picks a victim, fetches the line, fills the data
// array beat by beat, then installs the tag with valid=1.
module cache_refill_ctrl #(
    parameter int unsigned TAG_W  = cache_pkg::TAG_W,
    parameter int unsigned IDX_W  = cache_pkg::IDX_W,
    parameter int unsigned OFF_W  = cache_pkg::OFF_W,
    parameter int unsigned DATA_W = cache_pkg::DATA_W,
    parameter int unsigned BEATS  = cache_pkg::BEATS
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         req_valid,
    input  logic [TAG_W+IDX_W+OFF_W-1:0] req_addr,
    input  logic                         hit,
    input  logic [3:0]                   vbit,
    output logic                         stall,
    output logic                         mem_req,
    output logic [TAG_W+IDX_W+OFF_W-1:0] mem_addr,
    input  logic                         mem_ack,
    input  logic                         mem_rvalid,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         fill_we,
    output logic [1:0]                   fill_way,
    output logic [IDX_W-1:0]             fill_idx,
    output logic [$clog2(BEATS)-1:0]     fill_word,
    output logic [DATA_W-1:0]            fill_data,
    output logic                         tag_we,
    output logic [TAG_W-1:0]             tag_data,
    output logic                         refill_done
);

    import cache_pkg::*;

    localparam int unsigned ADDR_W = TAG_W + IDX_W + OFF_W;
    localparam int unsigned WORD_W = $clog2(BEATS);
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(BEATS - 1);

    refill_state_t     state_q, state_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    way_t              way_q, way_d;
    logic              from_ptr_q, from_ptr_d;
    logic [WORD_W-1:0] beat_q, beat_d;
    logic              fill_we_q, fill_we_d;
    logic [WORD_W-1:0] fill_word_q, fill_word_d;
    logic [DATA_W-1:0] fill_data_q, fill_data_d;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    way_t              sel_way;
    logic              sel_from_ptr;
    logic              ptr_upd;
    logic              unused_off;

    assign req_tag    = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx    = req_addr[OFF_W +: IDX_W];
    // Byte offset of the missing access is irrelevant: the whole line is fetched.
    assign unused_off = ^req_addr[OFF_W-1:0];

    // Only pointer-chosen victims move the pointer; an invalid-way fill leaves it alone.
    assign ptr_upd = (state_q == COMMIT) && from_ptr_q;

    victim_select #(
        .IDX_W (IDX_W)
    ) u_victim_select (
        .clk      (clk),
        .reset_n  (reset_n),
        .vbit     (vbit),
        .idx      (req_idx),
        .upd      (ptr_upd),
        .upd_idx  (idx_q),
        .upd_way  (way_q),
        .victim   (sel_way),
        .from_ptr (sel_from_ptr)
    );

    // Next-state logic: capture the miss in IDLE, then walk REQ -> FILL -> COMMIT.
    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        idx_d       = idx_q;
        way_d       = way_q;
        from_ptr_d  = from_ptr_q;
        beat_d      = beat_q;
        fill_we_d   = 1'b0;
        fill_word_d = fill_word_q;
        fill_data_d = fill_data_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && !hit) begin
                    tag_d      = req_tag;
                    idx_d      = req_idx;
                    way_d      = sel_way;
                    from_ptr_d = sel_from_ptr;
                    beat_d     = '0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                // Beats are not accepted until the cycle after the ack.
                if (mem_ack) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (mem_rvalid) begin
                    fill_we_d   = 1'b1;
                    fill_word_d = beat_q;
                    fill_data_d = mem_rdata;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = COMMIT;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-miss registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tag_q       <= '0;
            idx_q       <= '0;
            way_q       <= '0;
            from_ptr_q  <= 1'b0;
            beat_q      <= '0;
            fill_we_q   <= 1'b0;
            fill_word_q <= '0;
            fill_data_q <= '0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            idx_q       <= idx_d;
            way_q       <= way_d;
            from_ptr_q  <= from_ptr_d;
            beat_q      <= beat_d;
            fill_we_q   <= fill_we_d;
            fill_word_q <= fill_word_d;
            fill_data_q <= fill_data_d;
        end
    end

    // Outputs decoded from state and registered fill data.
    always_comb begin
        stall       = (state_q != IDLE);
        mem_req     = (state_q == REQ);
        mem_addr    = '0;
        if (mem_req) begin
            mem_addr = {tag_q, idx_q, {OFF_W{1'b0}}};
        end
        tag_we      = (state_q == COMMIT);
        refill_done = (state_q == COMMIT);
        tag_data    = tag_q;
        fill_we     = fill_we_q;
        fill_way    = way_q;
        fill_idx    = idx_q;
        fill_word   = fill_word_q;
        fill_data   = fill_data_q;
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: table of misses plus reset/hit sequences,
// with a scoreboard of expected fill and tag writes.
module tb_cache_refill_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic [45:0] req_addr;
    logic        hit;
    logic [3:0]  vbit;
    logic        stall;
    logic        mem_req;
    logic [45:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        fill_we;
    logic [1:0]  fill_way;
    logic [5:0]  fill_idx;
    logic [1:0]  fill_word;
    logic [31:0] fill_data;
    logic        tag_we;
    logic [35:0] tag_data;
    logic        refill_done;

    cache_refill_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .hit         (hit),
        .vbit        (vbit),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .fill_we     (fill_we),
        .fill_way    (fill_way),
        .fill_idx    (fill_idx),
        .fill_word   (fill_word),
        .fill_data   (fill_data),
        .tag_we      (tag_we),
        .tag_data    (tag_data),
        .refill_done (refill_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_tag;
        logic [1:0]  way;
        logic [5:0]  idx;
        logic [1:0]  word;
        logic [31:0] data;
        logic [35:0] tag;
    } exp_t;

    typedef struct {
        logic [35:0] tag;
        logic [5:0]  idx;
        logic [3:0]  vbit;
        logic [1:0]  exp_way;
        int          ack_dly;
        int          gap;
        bit          stray;
        bit          busy;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[13];
    int   checks = 0;
    int   errors = 0;
    int   stall_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_fill_we"}, fill_we, 0);
        chk({tag, "_fill_way"}, fill_way, 0);
        chk({tag, "_fill_idx"}, fill_idx, 0);
        chk({tag, "_fill_word"}, fill_word, 0);
        chk({tag, "_fill_data"}, fill_data, 0);
        chk({tag, "_tag_we"}, tag_we, 0);
        chk({tag, "_tag_data"}, tag_data, 0);
        chk({tag, "_refill_done"}, refill_done, 0);
    endtask

    // Scoreboard consumer: every fill/tag write must match the next expected entry.
    always @(negedge clk) begin
        if (reset_n) begin
            if (stall) stall_cnt++;
            if (fill_we) begin
                if (sb.size() == 0 || sb[0].is_tag) begin
                    fail("fill_unexpected");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("fill_way", fill_way, e.way);
                    chk("fill_idx", fill_idx, e.idx);
                    chk("fill_word", fill_word, e.word);
                    chk("fill_data", fill_data, e.data);
                end
            end
            if (tag_we) begin
                if (sb.size() == 0 || !sb[0].is_tag) begin
                    fail("tag_we_unexpected");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("tag_data", tag_data, e.tag);
                    chk("tag_way", fill_way, e.way);
                    chk("tag_idx", fill_idx, e.idx);
                    chk("refill_done", refill_done, 1);
                end
            end else if (refill_done) begin
                fail("refill_done_without_tag_we");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete miss; called 1 time unit after a rising edge with the FSM idle.
    task automatic run_miss(input vec_t v, input string name);
        logic [31:0] d[4];
        exp_t        e;
        logic [45:0] exp_addr;
        int          base;
        int          n;
        exp_addr = {v.tag, v.idx, 4'h0};
        for (int k = 0; k < 4; k++) begin
            d[k] = $urandom;
            e = '{is_tag: 1'b0, way: v.exp_way, idx: v.idx, word: 2'(k), data: d[k], tag: '0};
            sb.push_back(e);
        end
        e = '{is_tag: 1'b1, way: v.exp_way, idx: v.idx, word: '0, data: '0, tag: v.tag};
        sb.push_back(e);

        base      = stall_cnt;
        req_valid = 1'b1;
        hit       = 1'b0;
        req_addr  = {v.tag, v.idx, 4'h5};
        vbit      = v.vbit;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i <= v.ack_dly; i++) begin
            chk({name, "_mem_req"}, mem_req, 1);
            chk({name, "_mem_addr"}, mem_addr, exp_addr);
            mem_rvalid = v.stray;
            mem_rdata  = 32'hdead_beef;
            mem_ack    = (i == v.ack_dly);
            tick();
        end
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = d[k];
            if (v.busy) begin
                req_valid = 1'b1;
                hit       = 1'b0;
                req_addr  = {~v.tag, ~v.idx, 4'h0};
                vbit      = 4'h0;
            end
            tick();
            mem_rvalid = 1'b0;
            req_valid  = 1'b0;
            repeat (v.gap) tick();
        end
        n = 0;
        while (stall && n < 20) begin
            tick();
            n++;
        end
        if (stall) fail({name, "_stall_timeout"});
        chk({name, "_stall_cycles"}, stall_cnt - base, 6 + v.ack_dly + 3 * v.gap);
        chk({name, "_sb_drained"}, sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd0;
        logic [31:0] rd1;
        exp_t        e;
        vec_t        v;

        vecs[0]  = '{36'h1_2345_6789, 6'd5,  4'b0000, 2'd0, 0, 0, 1'b0, 1'b0};
        vecs[1]  = '{36'h0_0000_0a11, 6'd7,  4'b1011, 2'd2, 0, 0, 1'b0, 1'b0};
        vecs[2]  = '{36'h3_3333_0001, 6'd12, 4'b1011, 2'd2, 0, 0, 1'b0, 1'b0};
        vecs[3]  = '{36'h3_3333_0002, 6'd12, 4'b1111, 2'd0, 0, 0, 1'b0, 1'b0};
        vecs[4]  = '{36'h3_3333_0003, 6'd12, 4'b1111, 2'd1, 0, 0, 1'b0, 1'b0};
        vecs[5]  = '{36'h9_0000_0000, 6'd9,  4'b1111, 2'd0, 0, 0, 1'b0, 1'b0};
        vecs[6]  = '{36'h9_0000_0001, 6'd9,  4'b1111, 2'd1, 1, 0, 1'b0, 1'b0};
        vecs[7]  = '{36'h9_0000_0002, 6'd9,  4'b1111, 2'd2, 0, 1, 1'b0, 1'b0};
        vecs[8]  = '{36'h9_0000_0003, 6'd9,  4'b1111, 2'd3, 0, 0, 1'b0, 1'b0};
        vecs[9]  = '{36'h9_0000_0004, 6'd9,  4'b1111, 2'd0, 0, 0, 1'b0, 1'b0};
        vecs[10] = '{36'h5_a5a5_a5a5, 6'd20, 4'b0001, 2'd1, 3, 2, 1'b1, 1'b0};
        vecs[11] = '{36'hc_0ffe_e123, 6'd33, 4'b0111, 2'd3, 1, 1, 1'b0, 1'b1};
        vecs[12] = '{36'hf_ffff_fffe, 6'd63, 4'b1101, 2'd1, 0, 0, 1'b1, 1'b0};

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        hit        = 1'b0;
        vbit       = 4'h0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        #23;
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            run_miss(vecs[i], $sformatf("vec%0d", i));
        end

        // Hits in IDLE must not start a refill.
        req_valid = 1'b1;
        hit       = 1'b1;
        req_addr  = {36'h7_7777_7777, 6'd3, 4'h0};
        vbit      = 4'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hit_mem_req", mem_req, 0);
            chk("hit_stall", stall, 0);
        end
        req_valid = 1'b0;
        hit       = 1'b0;
        tick();

        // Reset in the middle of FILL, right after beat 1 is written.
        rd0 = $urandom;
        rd1 = $urandom;
        e = '{is_tag: 1'b0, way: 2'd2, idx: 6'd40, word: 2'd0, data: rd0, tag: '0};
        sb.push_back(e);
        e = '{is_tag: 1'b0, way: 2'd2, idx: 6'd40, word: 2'd1, data: rd1, tag: '0};
        sb.push_back(e);
        req_valid = 1'b1;
        req_addr  = {36'ha_bcde_1234, 6'd40, 4'h0};
        vbit      = 4'b0011;
        tick();
        req_valid = 1'b0;
        mem_ack   = 1'b1;
        tick();
        mem_ack    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rd0;
        tick();
        mem_rdata = rd1;
        tick();
        mem_rvalid = 1'b0;
        chk("pre_reset_fill_we", fill_we, 1);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_all_zero("midfill_reset");
        chk("midfill_sb_drained", sb.size(), 0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        tick();
        chk("post_reset_stall", stall, 0);
        chk("post_reset_tag_we", tag_we, 0);

        // Pointers cleared by reset: full set 9 picks way 0 again, beats restart at 0.
        v = '{36'h1_1111_2222, 6'd9, 4'b1111, 2'd0, 0, 0, 1'b0, 1'b0};
        run_miss(v, "after_reset");
        v = '{36'h1_1111_3333, 6'd9, 4'b1111, 2'd1, 2, 0, 1'b1, 1'b0};
        run_miss(v, "after_reset2");

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
